sensor_if_multi: RTL and testbench

- Parametrised multi-channel successor to the single-channel sensor interface in the light controller.
- Each of N_CH presence sensors is synchronised, debounced and tracked by a per-channel FSM (IDLE/ACTIVE/HOLD).
- The block reports per-channel occupancy, a one-cycle "passed" pulse when occupancy ends, and a global saturating pass counter.
- Feeds the light controller's lamp-timing logic.

---
 rtl/sensor_pkg.sv | 29 ++
 rtl/sensor_chan.sv | 160 ++++++++++++++++
 rtl/sensor_if_multi.sv | 70 +++++++
 tb/tb_sensor_if_multi.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_pkg.sv
// Shared types, default parameters and helpers for the multi-channel sensor interface.
// The optional stuck-sensor detection is enabled by defining STUCK_DETECT_EN.
package sensor_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HOLD   = 2'd2,
        FAULT  = 2'd3
    } chan_state_t;

    localparam int N_CH_DEF     = 4;
    localparam int DEBOUNCE_DEF = 4;
    localparam int HOLD_DEF     = 16;
    localparam int COUNT_W_DEF  = 8;
    localparam int STUCK_DEF    = 1024;
    localparam int MAX_CH       = 16;

    // Number of set bits in a channel vector (at most MAX_CH, so 5 bits suffice).
    function automatic logic [4:0] popcount(input logic [MAX_CH-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            c = c + {4'b0000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/sensor_chan.sv
// One presence-sensor channel: 2-flop synchroniser, debounce/hold counters and
// the occupancy FSM. With STUCK_DETECT_EN defined, a channel held active for
// STUCK_CYCLES is parked in FAULT until the sensor drops.
//
//   state  | meaning
//   IDLE   | no presence; counting consecutive high samples (debounce)
//   ACTIVE | presence confirmed; occupied
//   HOLD   | sensor dropped; still occupied while the hold timer runs
//   FAULT  | sensor stuck high too long (only with STUCK_DETECT_EN)
module sensor_chan
    import sensor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int HOLD_CYCLES     = HOLD_DEF,
    parameter int STUCK_CYCLES    = STUCK_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic sens_in,
    output logic occupied,
    output logic passed,
    output logic fault
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    logic              r_sync1, r_sync2;
    chan_state_t       r_state, w_state_nxt;
    logic [DEB_W-1:0]  r_deb, w_deb_nxt;
    logic [HOLD_W-1:0] r_hold, w_hold_nxt;
    logic              r_passed, w_passed_nxt;
    logic              w_deb_hit, w_hold_hit;

`ifdef STUCK_DETECT_EN
    localparam int STUCK_W = $clog2(STUCK_CYCLES + 1);
    logic [STUCK_W-1:0] r_stuck, w_stuck_nxt;
    logic               w_stuck_hit;
    assign w_stuck_hit = (r_stuck == STUCK_W'(STUCK_CYCLES - 1));
`endif

    assign w_deb_hit  = (r_deb == DEB_W'(DEBOUNCE_CYCLES - 1));
    assign w_hold_hit = (r_hold == HOLD_W'(HOLD_CYCLES - 1));

    // Two-flop synchroniser for the asynchronous sensor level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= sens_in;
            r_sync2 <= r_sync1;
        end
    end

    // State, counters and the registered pass pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_deb    <= '0;
            r_hold   <= '0;
            r_passed <= 1'b0;
`ifdef STUCK_DETECT_EN
            r_stuck  <= '0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_deb    <= w_deb_nxt;
            r_hold   <= w_hold_nxt;
            r_passed <= w_passed_nxt;
`ifdef STUCK_DETECT_EN
            r_stuck  <= w_stuck_nxt;
`endif
        end
    end

    // Next-state and counter update; the hold count is deliberately kept across
    // short high blips in HOLD so a flickering sensor cannot extend occupancy forever.
    always_comb begin
        w_state_nxt  = r_state;
        w_deb_nxt    = r_deb;
        w_hold_nxt   = r_hold;
        w_passed_nxt = 1'b0;
`ifdef STUCK_DETECT_EN
        w_stuck_nxt  = '0;
`endif
        case (r_state)
            IDLE: begin
                if (r_sync2) begin
                    if (w_deb_hit) begin
                        w_state_nxt = ACTIVE;
                        w_deb_nxt   = '0;
                    end else begin
                        w_deb_nxt = r_deb + DEB_W'(1);
                    end
                end else begin
                    w_deb_nxt = '0;
                end
            end
            ACTIVE: begin
                if (!r_sync2) begin
                    w_state_nxt = HOLD;
                    w_hold_nxt  = '0;
                    w_deb_nxt   = '0;
                end
`ifdef STUCK_DETECT_EN
                else if (w_stuck_hit) begin
                    w_state_nxt = FAULT;
                end else begin
                    w_stuck_nxt = r_stuck + STUCK_W'(1);
                end
`endif
            end
            HOLD: begin
                if (r_sync2) begin
                    if (w_deb_hit) begin
                        w_state_nxt = ACTIVE;
                        w_deb_nxt   = '0;
                    end else begin
                        w_deb_nxt = r_deb + DEB_W'(1);
                    end
                end else begin
                    w_deb_nxt = '0;
                    if (w_hold_hit) begin
                        w_state_nxt  = IDLE;
                        w_hold_nxt   = '0;
                        w_passed_nxt = 1'b1;
                    end else begin
                        w_hold_nxt = r_hold + HOLD_W'(1);
                    end
                end
            end
`ifdef STUCK_DETECT_EN
            FAULT: begin
                if (!r_sync2) begin
                    w_state_nxt = IDLE;
                    w_deb_nxt   = '0;
                end
            end
`endif
            default: begin
                w_state_nxt = IDLE;
                w_deb_nxt   = '0;
                w_hold_nxt  = '0;
            end
        endcase
    end

    assign occupied = (r_state == ACTIVE) || (r_state == HOLD);
    assign passed   = r_passed;

`ifdef STUCK_DETECT_EN
    assign fault = (r_state == FAULT);
`else
    logic w_unused_stuck;
    assign w_unused_stuck = |STUCK_CYCLES;
    assign fault = 1'b0;
`endif

endmodule

// File: rtl/sensor_if_multi.sv
// Multi-channel presence sensor interface: N_CH independent sensor_chan
// instances, an any-occupied summary and a saturating pass counter.
// Stuck-sensor detection is compiled in when STUCK_DETECT_EN is defined.
module sensor_if_multi
    import sensor_pkg::*;
#(
    parameter int N_CH            = N_CH_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int HOLD_CYCLES     = HOLD_DEF,
    parameter int COUNT_W         = COUNT_W_DEF,
    parameter int STUCK_CYCLES    = STUCK_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_CH-1:0]    sens_active,
    input  logic               count_clr,
    output logic [N_CH-1:0]    occupied,
    output logic [N_CH-1:0]    passed,
    output logic               any_occupied,
    output logic [COUNT_W-1:0] pass_count,
    output logic [N_CH-1:0]    fault
);

    localparam int SUM_W = COUNT_W + 5;

    logic [N_CH-1:0]    w_occupied, w_passed, w_fault;
    logic [4:0]         w_inc;
    logic [SUM_W-1:0]   w_sum;
    logic [COUNT_W-1:0] w_max;
    logic [COUNT_W-1:0] r_count;

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        sensor_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .STUCK_CYCLES    (STUCK_CYCLES)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .sens_in  (sens_active[g]),
            .occupied (w_occupied[g]),
            .passed   (w_passed[g]),
            .fault    (w_fault[g])
        );
    end

    assign w_inc = popcount(MAX_CH'(w_passed));
    assign w_max = {COUNT_W{1'b1}};
    assign w_sum = SUM_W'(r_count) + SUM_W'(w_inc);

    // Saturating pass counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (count_clr) begin
            r_count <= '0;
        end else if (w_sum > SUM_W'(w_max)) begin
            r_count <= w_max;
        end else begin
            r_count <= w_sum[COUNT_W-1:0];
        end
    end

    assign occupied     = w_occupied;
    assign passed       = w_passed;
    assign fault        = w_fault;
    assign any_occupied = |w_occupied;
    assign pass_count   = r_count;

endmodule

// File: tb/tb_sensor_if_multi.sv
// Self-checking bench for sensor_if_multi: directed scenarios plus random
// sensor levels, all compared every cycle against an occupancy model built
// from run lengths of the synchronised input. STUCK_DETECT_EN adds a stuck test.
module tb_sensor_if_multi;

    localparam int N   = 4;
    localparam int D   = 4;
    localparam int H   = 16;
    localparam int CW  = 8;
    localparam int STK = 1024;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [N-1:0]  sens_active = '0;
    logic          count_clr = 1'b0;
    logic [N-1:0]  occupied, passed, fault;
    logic          any_occupied;
    logic [CW-1:0] pass_count;

    int n_vec = 0;
    int n_err = 0;

    // model state
    logic [N-1:0] m_s1, m_s2, m_occ, m_hold, m_flt, m_passed;
    int           m_run [N];
    int           m_lows[N];
    int           m_act [N];
    int           m_count;

    // observation accumulators for directed scenarios
    int           acc_pulses[N];
    logic [N-1:0] acc_occ_or, acc_occ_and;
    logic [N-1:0] acc_passed_max;

    always #5 clk = ~clk;

    sensor_if_multi #(
        .N_CH(N), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .COUNT_W(CW), .STUCK_CYCLES(STK)
    ) dut (
        .clk(clk), .reset(reset), .sens_active(sens_active), .count_clr(count_clr),
        .occupied(occupied), .passed(passed), .any_occupied(any_occupied),
        .pass_count(pass_count), .fault(fault)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Occupancy model: a channel becomes occupied after D consecutive high
    // samples, then stays occupied until H+1 low samples (counting the one that
    // ended activity) accumulate without an intervening run of D highs.
    task automatic model_edge();
        logic s;
        if (!reset) begin
            m_s1 = '0; m_s2 = '0; m_occ = '0; m_hold = '0; m_flt = '0; m_passed = '0;
            m_count = 0;
            for (int i = 0; i < N; i++) begin
                m_run[i] = 0; m_lows[i] = 0; m_act[i] = 0;
            end
            return;
        end
        if (count_clr) m_count = 0;
        else begin
            m_count = m_count + $countones(m_passed);
            if (m_count > CMAX) m_count = CMAX;
        end
        for (int i = 0; i < N; i++) begin
            s = m_s2[i];
            m_passed[i] = 1'b0;
            m_run[i] = s ? m_run[i] + 1 : 0;
            if (m_flt[i]) begin
                if (!s) m_flt[i] = 1'b0;
            end else if (!m_occ[i]) begin
                if (s && m_run[i] == D) begin
                    m_occ[i] = 1'b1; m_hold[i] = 1'b0; m_act[i] = 0;
                end
            end else if (!m_hold[i]) begin
                if (!s) begin
                    m_hold[i] = 1'b1; m_lows[i] = 1;
                end else begin
`ifdef STUCK_DETECT_EN
                    m_act[i]++;
                    if (m_act[i] == STK) begin
                        m_occ[i] = 1'b0; m_flt[i] = 1'b1;
                    end
`endif
                end
            end else begin
                if (s) begin
                    if (m_run[i] == D) begin
                        m_hold[i] = 1'b0; m_act[i] = 0;
                    end
                end else begin
                    m_lows[i]++;
                    if (m_lows[i] == H + 1) begin
                        m_occ[i] = 1'b0; m_hold[i] = 1'b0; m_passed[i] = 1'b1;
                    end
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = sens_active;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("occupied", 32'(occupied), 32'(m_occ));
        chk("passed", 32'(passed), 32'(m_passed));
        chk("any_occupied", 32'(any_occupied), 32'(|m_occ));
        chk("pass_count", 32'(pass_count), 32'(m_count));
        chk("fault", 32'(fault), 32'(m_flt));
        for (int i = 0; i < N; i++) acc_pulses[i] += int'(passed[i]);
        acc_occ_or  = acc_occ_or | occupied;
        acc_occ_and = acc_occ_and & occupied;
        acc_passed_max = (passed > acc_passed_max) ? passed : acc_passed_max;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic clear_acc();
        for (int i = 0; i < N; i++) acc_pulses[i] = 0;
        acc_occ_or = '0; acc_occ_and = '1; acc_passed_max = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0; run(2); reset = 1'b1;
    endtask

    task automatic burst(input logic [N-1:0] mask);
        sens_active = mask; run(10);
        sens_active = '0;   run(22);
    endtask

    int lvl_cnt[N];
    logic found;

    initial begin
        clear_acc();
        // reset with all sensors high, then release: occupied after e0+5
        sens_active = '1;
        do_reset();
        chk("rst_occupied", 32'(occupied), 32'h0);
        chk("rst_pass_count", 32'(pass_count), 32'h0);
        run(5);
        chk("rise_early", 32'(occupied), 32'h0);
        run(1);
        chk("rise_e0p5", 32'(occupied), 32'hF);

        // glitch reject on ch0
        sens_active = '0; do_reset(); clear_acc();
        sens_active = 4'b0001; run(3);
        sens_active = '0; run(30);
        chk("glitch_occ", 32'(acc_occ_or), 32'h0);
        chk("glitch_cnt", 32'(pass_count), 32'h0);

        // full pass on ch1: pulse after e0+18 of the falling level
        clear_acc();
        sens_active = 4'b0010; run(20);
        sens_active = '0; run(18);
        chk("full_occ_hold", 32'(occupied), 32'h2);
        run(1);
        chk("full_pulse", 32'(passed), 32'h2);
        chk("full_occ_fall", 32'(any_occupied), 32'h0);
        run(1);
        chk("full_cnt", 32'(pass_count), 32'h1);
        chk("full_one_pulse", 32'(acc_pulses[1]), 32'd1);

        // retrigger on ch2 during HOLD
        run(5); clear_acc();
        sens_active = 4'b0100; run(10);
        sens_active = '0; run(8);
        sens_active = 4'b0100; run(10);
        chk("retrig_no_pulse", 32'(acc_pulses[2]), 32'd0);
        sens_active = '0; run(25);
        chk("retrig_one_pulse", 32'(acc_pulses[2]), 32'd1);
        chk("retrig_cnt", 32'(pass_count), 32'd2);

        // simultaneous passes on all channels
        clear_acc();
        burst(4'hF);
        chk("simul_pulse", 32'(acc_passed_max), 32'hF);
        chk("simul_cnt", 32'(pass_count), 32'd6);

        // saturation: clear, climb to 253, then saturate
        count_clr = 1'b1; tick(); count_clr = 1'b0;
        for (int b = 0; b < 63; b++) burst(4'hF);
        burst(4'b1000);
        chk("sat_253", 32'(pass_count), 32'd253);
        burst(4'hF);
        chk("sat_255", 32'(pass_count), 32'd255);
        burst(4'hF);
        chk("sat_hold", 32'(pass_count), 32'd255);

        // count_clr on the same edge the pulse is counted
        sens_active = 4'hF; run(10);
        sens_active = '0; found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            tick();
            found = (passed != '0);
        end
        chk("clr_wait", 32'(found), 32'd1);
        count_clr = 1'b1; tick(); count_clr = 1'b0;
        chk("clr_wins", 32'(pass_count), 32'd0);

        // reset in the middle of ch3 HOLD
        run(5); clear_acc();
        sens_active = 4'b1000; run(10);
        sens_active = '0; run(8);
        chk("midhold_occ", 32'(occupied), 32'h8);
        reset = 1'b0; tick(); reset = 1'b1;
        chk("midhold_rst_occ", 32'(occupied), 32'h0);
        run(30);
        chk("midhold_no_pulse", 32'(acc_pulses[3]), 32'd0);

`ifdef STUCK_DETECT_EN
        clear_acc();
        sens_active = 4'b0001; run(1100);
        chk("stuck_fault", 32'(fault), 32'h1);
        chk("stuck_occ", 32'(occupied), 32'h0);
        sens_active = '0; run(5);
        chk("stuck_clear", 32'(fault), 32'h0);
        chk("stuck_no_pulse", 32'(acc_pulses[0]), 32'd0);
`endif

        // random levels with occasional clears and resets
        for (int i = 0; i < N; i++) lvl_cnt[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (lvl_cnt[i] == 0) begin
                    sens_active[i] = 1'($urandom_range(0, 1));
                    lvl_cnt[i] = $urandom_range(1, 24);
                end else begin
                    lvl_cnt[i]--;
                end
            end
            count_clr = ($urandom_range(0, 63) == 0);
            reset = ($urandom_range(0, 499) != 0);
            tick();
        end
        reset = 1'b1; count_clr = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
